// File: rtl/gates_seq_ctrl_pkg.sv
// Shared definitions for the gate-unit sequencer.
//   - FSM state encodings (3-bit)
//   - Expected gate-unit result per input vector {A,B}
//     Z bit order: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
package gates_seq_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [5:0] EXP_Z_00 = 6'h2A;
  localparam logic [5:0] EXP_Z_01 = 6'h16;
  localparam logic [5:0] EXP_Z_10 = 6'h16;
  localparam logic [5:0] EXP_Z_11 = 6'h25;

  function automatic logic [5:0] expected_z(input logic [1:0] ab);
    logic [5:0] z;
    case (ab)
      2'b00:   z = EXP_Z_00;
      2'b01:   z = EXP_Z_01;
      2'b10:   z = EXP_Z_10;
      default: z = EXP_Z_11;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/gates_settle_cnt.sv
// Loadable down-counter with zero flag, used to time the settle window.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load, CNT_W bits
//   dec_i      : decrement by one; holds at zero
//   zero_o     : count is zero
module gates_settle_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gates_seq_ctrl.sv
// Sequencer / self-checker for the six-output two-input gate unit.
// A start request walks {A,B} through 00,01,10,11; each vector is driven,
// allowed to settle for SETTLE_CYCLES, then Z is compared with the
// expected truth table. Mismatches accumulate in a sticky err_mask.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : run request, sampled in IDLE
//   A, B      : gate-unit inputs
//   Z         : gate-unit result bus (synchronous to clk)
//   busy      : run in progress
//   done      : one-cycle end-of-run pulse
//   pass      : last completed run had no errors
//   err_mask  : sticky per-gate error mask
//   vec_idx   : current vector {A,B}
// Optional build macro GATES_SEQ_LOOP_EN: with start held high, DONE
// restarts directly at vector 0 and err_mask stays sticky across runs.
module gates_seq_ctrl
  import gates_seq_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic [5:0] Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [1:0] vec_idx
);

  logic [2:0] state_q, state_d;
  logic       a_q, b_q, busy_q, done_q, pass_q;
  logic [5:0] err_q;
  logic [1:0] vec_q;
  logic       cnt_load, cnt_dec, cnt_zero;

  gates_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(SETTLE_CYCLES - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE: begin
        cnt_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      // Loaded with SETTLE_CYCLES-1 so the zero cycle is the last settle cycle.
      ST_SETTLE: begin
        if (cnt_zero) state_d = ST_CHECK;
        else          cnt_dec = 1'b1;
      end
      ST_CHECK:  state_d = (vec_q == 2'd3) ? ST_DONE : ST_DRIVE;
`ifdef GATES_SEQ_LOOP_EN
      ST_DONE:   state_d = start ? ST_DRIVE : ST_IDLE;
`else
      ST_DONE:   state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 6'h00;
      vec_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vec_q  <= 2'd0;
            err_q  <= 6'h00;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        ST_DRIVE: {a_q, b_q} <= vec_q;
        ST_CHECK: begin
          err_q <= err_q | (Z ^ expected_z(vec_q));
          if (vec_q != 2'd3) vec_q <= vec_q + 2'd1;
        end
        ST_DONE: begin
          done_q <= 1'b1;
          pass_q <= (err_q == 6'h00);
`ifdef GATES_SEQ_LOOP_EN
          if (start) vec_q  <= 2'd0;
          else       busy_q <= 1'b0;
`else
          busy_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_mask = err_q;
  assign vec_idx  = vec_q;

endmodule

// File: tb/tb_gates_seq_ctrl.sv
module tb_gates_seq_ctrl;

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

`ifdef GATES_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       a_w [3];
  logic       b_w [3];
  logic [5:0] z_w [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic [5:0] err_w [3];
  logic [1:0] vec_w [3];

  logic [5:0] stuck  [3];
  logic [5:0] flip   [3];
  logic [5:0] glitch [3];

  int n_chk;
  int n_pass;

  // Behavioural gate unit: bit 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  function automatic logic [5:0] gate_ref(input logic a, input logic b);
    logic [5:0] z;
    z[0] = a & b;
    z[1] = ~(a & b);
    z[2] = a | b;
    z[3] = ~(a | b);
    z[4] = a ^ b;
    z[5] = ~(a ^ b);
    return z;
  endfunction

  // Errors a faulty unit produces over all four vectors
  function automatic logic [5:0] model_err(input logic [5:0] st, input logic [5:0] fl);
    logic [5:0] e;
    logic [1:0] ab;
    e = 6'h00;
    for (int v = 0; v < 4; v++) begin
      ab = 2'(v);
      e = e | (((gate_ref(ab[1], ab[0]) & ~st) ^ fl) ^ gate_ref(ab[1], ab[0]));
    end
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign z_w[g] = ((gate_ref(a_w[g], b_w[g]) & ~stuck[g]) ^ flip[g]) ^ glitch[g];
    gates_seq_ctrl #(.SETTLE_CYCLES(settle_of(g)), .CNT_W(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .A        (a_w[g]),
      .B        (b_w[g]),
      .Z        (z_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .pass     (pass_w[g]),
      .err_mask (err_w[g]),
      .vec_idx  (vec_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero_all(input string tag);
    for (int k = 0; k < 3; k++)
      chk(tag, 32'({a_w[k], b_w[k], busy_w[k], done_w[k], pass_w[k], err_w[k], vec_w[k]}), 32'd0);
  endtask

  // One run on all three instances; interval c counts from the start-sampling edge.
  task automatic run_seq(input int rst_at, input bit repulse, input logic [5:0] gl);
    int ndone [3];
    int done_c [3];
    int s;
    int p;
    logic [1:0] v;
    logic [5:0] exp_e;
    for (int k = 0; k < 3; k++) begin
      ndone[k]  = 0;
      done_c[k] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 36; c++) begin
      for (int k = 0; k < 3; k++) begin
        s = settle_of(k);
        p = s + 2;
        glitch[k] = (c < 4 * p && (c % p) >= 1 && (c % p) <= s) ? gl : 6'h00;
      end
      if (repulse) start = (c == 5);
      if (c == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        chk_zero_all("async_rst");
        for (int k = 0; k < 3; k++) glitch[k] = 6'h00;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        s = settle_of(k);
        p = s + 2;
        if (done_w[k]) begin
          ndone[k]++;
          done_c[k] = c;
        end
        if (c < 4 * p && (c % p) == s + 1) begin
          v = 2'(c / p);
          chk("ab_vec", 32'({a_w[k], b_w[k], vec_w[k]}), 32'({v, v}));
        end
        if (c == 4 * p)     chk("busy_run", 32'(busy_w[k]), 32'd1);
        if (c == 4 * p + 1) chk("busy_end", 32'(busy_w[k]), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      glitch[k] = 6'h00;
      p = settle_of(k) + 2;
      exp_e = model_err(stuck[k], flip[k]);
      chk("done_cnt", 32'(ndone[k]), 32'd1);
      chk("done_cyc", 32'(done_c[k]), 32'(4 * p + 1));
      chk("err_mask", 32'(err_w[k]), 32'(exp_e));
      chk("pass", 32'(pass_w[k]), 32'(exp_e == 6'h00));
    end
  endtask

  // Start held for three runs on instance 0; Z[0] faulted only during run 2.
  task automatic run_hold();
    int p, len, st1, st2, nd, busy_low;
    int dc [3];
    logic [5:0] e_at [3];
    logic       p_at [3];
    p   = settle_of(0) + 2;
    len = 4 * p + 1;
    st1 = len + (LOOP_EN ? 0 : 1);
    st2 = 2 * st1;
    nd = 0;
    busy_low = 0;
    for (int r = 0; r < 3; r++) begin
      dc[r] = -1;
      e_at[r] = 6'h3F;
      p_at[r] = 1'bx;
    end
    for (int k = 0; k < 3; k++) begin
      stuck[k] = 6'h00;
      flip[k]  = 6'h00;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < st2 + len + 3; c++) begin
      flip[0] = (c >= st1 && c < st1 + len) ? 6'h01 : 6'h00;
      if (c == st2 + 1) start = 1'b0;
      @(negedge clk);
      if (done_w[0]) begin
        if (nd < 3) begin
          dc[nd]   = c;
          e_at[nd] = err_w[0];
          p_at[nd] = pass_w[0];
        end
        nd++;
      end
      if (c < st2 + len && !busy_w[0]) busy_low++;
      @(posedge clk);
      #1;
    end
    flip[0] = 6'h00;
    chk("hold_done_cnt", 32'(nd), 32'd3);
    chk("hold_done1", 32'(dc[0]), 32'(len));
    chk("hold_done2", 32'(dc[1]), 32'(st1 + len));
    chk("hold_done3", 32'(dc[2]), 32'(st2 + len));
    chk("hold_err1", 32'(e_at[0]), 32'h00);
    chk("hold_pass1", 32'(p_at[0]), 32'd1);
    chk("hold_err2", 32'(e_at[1]), 32'h01);
    chk("hold_pass2", 32'(p_at[1]), 32'd0);
    chk("hold_err3", 32'(e_at[2]), LOOP_EN ? 32'h01 : 32'h00);
    chk("hold_pass3", 32'(p_at[2]), LOOP_EN ? 32'd0 : 32'd1);
    chk("hold_busy_low", 32'(busy_low), LOOP_EN ? 32'd0 : 32'd2);
    repeat (40) @(posedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stuck[k]  = 6'h00;
      flip[k]   = 6'h00;
      glitch[k] = 6'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_all("reset_state");
    rst = 1'b0;

    // Fault-free run on all instances
    run_seq(-1, 1'b0, 6'h00);

    // XOR stuck at 0, NAND inverted, clean; Z glitching during settle; start re-pulsed
    stuck[0] = 6'h10;
    flip[1]  = 6'h02;
    run_seq(-1, 1'b1, 6'h3F);

    // Asynchronous reset during vector 2 settle, then a clean run
    run_seq(9, 1'b0, 6'h00);
    for (int k = 0; k < 3; k++) begin
      stuck[k] = 6'h00;
      flip[k]  = 6'h00;
    end
    run_seq(-1, 1'b0, 6'h00);

    // Randomized faults, glitches and stray start pulses
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        stuck[k] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
        flip[k]  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      end
      run_seq(-1, 1'($urandom_range(0, 1)), 6'($urandom));
    end

    run_hold();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
